spi_host_regs: RTL



---
 rtl/spi_host_regs.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/spi_host_regs.sv
`default_nettype none
// ============================================================================
// Module   : spi_host_regs
// Brief    : SPI host register block with CTRL/STATUS and TX/RX byte FIFOs.
//            Optional interrupt logic enabled by SPI_HOST_REGS_IRQ_EN.
// Revision : 1.0
// ============================================================================
module spi_host_regs #(
  parameter int  RegAw     = 6,
  parameter int  FifoDepth = 8,
  localparam int LW        = $clog2(FifoDepth) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             re_i,
  input  logic             we_i,
  input  logic [RegAw-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  input  logic [3:0]       be_i,
  output logic             busy_o,
  output logic [31:0]      rdata_o,
  output logic             error_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  output logic [7:0]       tx_data_o,
  input  logic             rx_valid_i,
  input  logic [7:0]       rx_data_i,
  input  logic             core_busy_i,
  output logic             cfg_en_o,
  output logic             cfg_cpol_o,
  output logic             cfg_cpha_o,
  output logic [7:0]       cfg_clkdiv_o,
  output logic             irq_o
);

  localparam int PW = $clog2(FifoDepth);
  localparam logic [LW-1:0]    c_FULL      = LW'(FifoDepth);
  localparam logic [RegAw-1:0] c_ADDR_CTRL = RegAw'(32'h00);
  localparam logic [RegAw-1:0] c_ADDR_STAT = RegAw'(32'h04);
  localparam logic [RegAw-1:0] c_ADDR_TXD  = RegAw'(32'h08);
  localparam logic [RegAw-1:0] c_ADDR_RXD  = RegAw'(32'h0C);
  localparam logic [RegAw-1:0] c_ADDR_INTR = RegAw'(32'h10);

  logic [7:0]    r_tx_mem [FifoDepth];
  logic [7:0]    r_rx_mem [FifoDepth];
  logic [PW-1:0] r_tx_wptr, r_tx_rptr, r_rx_wptr, r_rx_rptr;
  logic [LW-1:0] r_tx_level, r_rx_level;
  logic          r_rx_ovf;
  logic [2:0]    r_mode;
  logic [7:0]    r_clkdiv;

  logic w_sel_ctrl, w_sel_stat, w_sel_txd, w_sel_rxd, w_sel_intr, w_mapped;
  logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_rx_drop, w_ovf_clr, w_ovf_nxt;
  logic [LW-1:0] w_tx_level_nxt, w_rx_level_nxt;
  logic [31:0]   w_status, w_intr_rdata;
  logic          w_unused;

  assign w_sel_ctrl = (addr_i == c_ADDR_CTRL);
  assign w_sel_stat = (addr_i == c_ADDR_STAT);
  assign w_sel_txd  = (addr_i == c_ADDR_TXD);
  assign w_sel_rxd  = (addr_i == c_ADDR_RXD);
  assign w_mapped   = w_sel_ctrl | w_sel_stat | w_sel_txd | w_sel_rxd | w_sel_intr;

  assign w_tx_full  = (r_tx_level == c_FULL);
  assign w_tx_empty = (r_tx_level == '0);
  assign w_rx_full  = (r_rx_level == c_FULL);
  assign w_rx_empty = (r_rx_level == '0);

  // Errored accesses are excluded from every state-changing strobe below.
  assign w_tx_push = we_i & w_sel_txd & be_i[0] & ~w_tx_full;
  assign w_tx_pop  = ~w_tx_empty & tx_ready_i;
  assign w_rx_pop  = re_i & w_sel_rxd & ~w_rx_empty;
  assign w_rx_push = rx_valid_i & (~w_rx_full | w_rx_pop);
  assign w_rx_drop = rx_valid_i & w_rx_full & ~w_rx_pop;
  assign w_ovf_clr = we_i & w_sel_stat & be_i[3] & wdata_i[24];
  assign w_ovf_nxt = w_rx_drop | (r_rx_ovf & ~w_ovf_clr);

  assign w_tx_level_nxt = r_tx_level + LW'(w_tx_push) - LW'(w_tx_pop);
  assign w_rx_level_nxt = r_rx_level + LW'(w_rx_push) - LW'(w_rx_pop);

  assign busy_o  = w_sel_txd & w_tx_full;
  assign error_o = (re_i & (~w_mapped | (w_sel_rxd & w_rx_empty)))
                 | (we_i & (~w_mapped | w_sel_rxd | (w_sel_txd & w_tx_full)));

  assign tx_valid_o   = ~w_tx_empty;
  assign tx_data_o    = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rptr];
  assign cfg_en_o     = r_mode[0];
  assign cfg_cpol_o   = r_mode[1];
  assign cfg_cpha_o   = r_mode[2];
  assign cfg_clkdiv_o = r_clkdiv;
  assign w_unused     = ^{wdata_i, be_i};

  always_ff @(posedge clk_i) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= wdata_i[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= rx_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tx_wptr  <= '0;
      r_tx_rptr  <= '0;
      r_rx_wptr  <= '0;
      r_rx_rptr  <= '0;
      r_tx_level <= '0;
      r_rx_level <= '0;
      r_rx_ovf   <= 1'b0;
      r_mode     <= 3'b000;
      r_clkdiv   <= 8'h00;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + PW'(1);
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + PW'(1);
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + PW'(1);
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + PW'(1);
      r_tx_level <= w_tx_level_nxt;
      r_rx_level <= w_rx_level_nxt;
      r_rx_ovf   <= w_ovf_nxt;
      if (we_i & w_sel_ctrl & be_i[0]) r_mode   <= wdata_i[2:0];
      if (we_i & w_sel_ctrl & be_i[1]) r_clkdiv <= wdata_i[15:8];
    end
  end

  always_comb begin
    w_status         = '0;
    w_status[0]      = w_tx_full;
    w_status[1]      = w_tx_empty;
    w_status[2]      = w_rx_full;
    w_status[3]      = w_rx_empty;
    w_status[4]      = core_busy_i;
    w_status[8+:LW]  = r_tx_level;
    w_status[16+:LW] = r_rx_level;
    w_status[24]     = r_rx_ovf;
  end

  always_comb begin
    rdata_o = '0;
    if (w_sel_ctrl)                   rdata_o = {16'h0000, r_clkdiv, 5'b00000, r_mode};
    else if (w_sel_stat)              rdata_o = w_status;
    else if (w_sel_rxd && !w_rx_empty) rdata_o = {24'h000000, r_rx_mem[r_rx_rptr]};
    else if (w_sel_intr)              rdata_o = w_intr_rdata;
  end

`ifdef SPI_HOST_REGS_IRQ_EN
  logic          r_rx_ie, r_ovf_ie, r_irq;
  logic [LW-1:0] r_rx_wm;
  logic          w_intr_we, w_rx_ie_nxt, w_ovf_ie_nxt, w_irq_nxt;
  logic [LW-1:0] w_rx_wm_nxt;

  assign w_sel_intr   = (addr_i == c_ADDR_INTR);
  assign w_intr_we    = we_i & w_sel_intr;
  assign w_rx_ie_nxt  = (w_intr_we & be_i[0]) ? wdata_i[0]    : r_rx_ie;
  assign w_ovf_ie_nxt = (w_intr_we & be_i[0]) ? wdata_i[1]    : r_ovf_ie;
  assign w_rx_wm_nxt  = (w_intr_we & be_i[1]) ? wdata_i[8+:LW] : r_rx_wm;
  // Evaluated on next-state values so irq_o tracks the registers it is derived from.
  assign w_irq_nxt = (w_rx_ie_nxt & (w_rx_level_nxt >= w_rx_wm_nxt) & (w_rx_wm_nxt != '0))
                   | (w_ovf_ie_nxt & w_ovf_nxt);
  assign irq_o = r_irq;

  always_comb begin
    w_intr_rdata        = '0;
    w_intr_rdata[0]     = r_rx_ie;
    w_intr_rdata[1]     = r_ovf_ie;
    w_intr_rdata[8+:LW] = r_rx_wm;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rx_ie  <= 1'b0;
      r_ovf_ie <= 1'b0;
      r_rx_wm  <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_rx_ie  <= w_rx_ie_nxt;
      r_ovf_ie <= w_ovf_ie_nxt;
      r_rx_wm  <= w_rx_wm_nxt;
      r_irq    <= w_irq_nxt;
    end
  end
`else
  assign w_sel_intr   = 1'b0;
  assign w_intr_rdata = '0;
  assign irq_o        = 1'b0;
`endif

endmodule
`default_nettype wire
